// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register busy scoreboard.
// Same-cycle write forwarding to the read ports is optional, and r0 can be hardwired to zero.
module regfile_mp #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUMREGS = 8,
    parameter int unsigned NUMRD   = 2,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = $clog2(NUMREGS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_write,
    input  logic [AW-1:0]            i_addrw,
    input  logic [WIDTH-1:0]         i_data_in,
    input  logic                     i_claim,
    input  logic [AW-1:0]            i_addrc,
    input  logic [NUMRD*AW-1:0]      i_addr_rd,
    output logic [NUMRD*WIDTH-1:0]   o_data_rd,
    output logic [NUMRD-1:0]         o_busy_rd,
    output logic [NUMREGS-1:0]       o_busy,
    output logic [NUMREGS*WIDTH-1:0] o_regs
);

    logic [WIDTH-1:0]   regs_q [NUMREGS];
    logic [WIDTH-1:0]   regs_d [NUMREGS];
    logic [NUMREGS-1:0] busy_q;
    logic [NUMREGS-1:0] busy_d;

    logic wr_is_zero;
    logic cl_is_zero;

    assign wr_is_zero = ZERO_R0 && (i_addrw == '0);
    assign cl_is_zero = ZERO_R0 && (i_addrc == '0);

    // Writeback clears busy first so that a same-address claim ends up winning.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (i_write) begin
            if (!wr_is_zero) begin
                regs_d[i_addrw] = i_data_in;
            end
            busy_d[i_addrw] = 1'b0;
        end
        if (i_claim && !cl_is_zero) begin
            busy_d[i_addrc] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUMREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUMRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          hit_wr;
        logic          hit_cl;

        assign addr    = i_addr_rd[p*AW +: AW];
        assign is_zero = ZERO_R0 && (addr == '0);
        assign hit_wr  = BYPASS && i_write && (i_addrw == addr);
        assign hit_cl  = i_claim && (i_addrc == addr);

        assign o_data_rd[p*WIDTH +: WIDTH] = is_zero ? '0 :
                                             hit_wr  ? i_data_in : regs_q[addr];
        // A forwarded write shows the register as free unless it is re-claimed this cycle.
        assign o_busy_rd[p] = is_zero ? 1'b0 :
                              hit_wr  ? hit_cl : busy_q[addr];
    end

    assign o_busy = busy_q;

    for (genvar i = 0; i < NUMREGS; i++) begin : g_regs
        assign o_regs[i*WIDTH +: WIDTH] = regs_q[i];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp; two instances (bypass / zero-r0+no-bypass)
// share one stimulus stream and are compared against an array-based reference model.
module tb_regfile_mp;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int R  = 3;
    localparam int AW = 3;

    logic            clk;
    logic            rst;
    logic            wr;
    logic [AW-1:0]   addrw;
    logic [W-1:0]    din;
    logic            claim;
    logic [AW-1:0]   addrc;
    logic [R*AW-1:0] addr_rd;

    logic [R*W-1:0]  data_a, data_b;
    logic [R-1:0]    busy_rd_a, busy_rd_b;
    logic [N-1:0]    busy_a, busy_b;
    logic [N*W-1:0]  regs_a, regs_b;

    int checks = 0;
    int errs   = 0;

    // Reference model state, per configuration (0: bypass, 1: zero-r0 without bypass).
    logic [W-1:0] mr [2][N];
    logic         mb [2][N];
    bit           cfg_z [2] = '{1'b0, 1'b1};
    bit           cfg_b [2] = '{1'b1, 1'b0};

    regfile_mp #(.WIDTH(W), .NUMREGS(N), .NUMRD(R), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_addrw(addrw), .i_data_in(din),
        .i_claim(claim), .i_addrc(addrc), .i_addr_rd(addr_rd),
        .o_data_rd(data_a), .o_busy_rd(busy_rd_a), .o_busy(busy_a), .o_regs(regs_a)
    );

    regfile_mp #(.WIDTH(W), .NUMREGS(N), .NUMRD(R), .ZERO_R0(1'b1), .BYPASS(1'b0)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_write(wr), .i_addrw(addrw), .i_data_in(din),
        .i_claim(claim), .i_addrc(addrc), .i_addr_rd(addr_rd),
        .o_data_rd(data_b), .o_busy_rd(busy_rd_b), .o_busy(busy_b), .o_regs(regs_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input int c, input logic [AW-1:0] a);
        if (cfg_z[c] && a == 0) return '0;
        if (cfg_b[c] && wr && addrw == a) return din;
        return mr[c][a];
    endfunction

    function automatic logic exp_brd(input int c, input logic [AW-1:0] a);
        if (cfg_z[c] && a == 0) return 1'b0;
        if (cfg_b[c] && wr && addrw == a) return claim && (addrc == a);
        return mb[c][a];
    endfunction

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    mr[c][i] = '0;
                    mb[c][i] = 1'b0;
                end
            end else begin
                if (wr) begin
                    if (!(cfg_z[c] && addrw == 0)) mr[c][addrw] = din;
                    mb[c][addrw] = 1'b0;
                end
                if (claim && !(cfg_z[c] && addrc == 0)) mb[c][addrc] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [R*W-1:0] d;
        logic [R-1:0]   brd;
        logic [N-1:0]   bv, ebv;
        logic [N*W-1:0] rv, erv;
        for (int c = 0; c < 2; c++) begin
            d   = (c == 0) ? data_a : data_b;
            brd = (c == 0) ? busy_rd_a : busy_rd_b;
            bv  = (c == 0) ? busy_a : busy_b;
            rv  = (c == 0) ? regs_a : regs_b;
            for (int p = 0; p < R; p++) begin
                check_eq($sformatf("c%0d_rd%0d", c, p), 128'(d[p*W +: W]),
                         128'(exp_rd(c, addr_rd[p*AW +: AW])));
                check_eq($sformatf("c%0d_busyrd%0d", c, p), 128'(brd[p]),
                         128'(exp_brd(c, addr_rd[p*AW +: AW])));
            end
            for (int i = 0; i < N; i++) begin
                ebv[i]         = mb[c][i];
                erv[i*W +: W]  = mr[c][i];
            end
            check_eq($sformatf("c%0d_busy", c), 128'(bv), 128'(ebv));
            check_eq($sformatf("c%0d_regs", c), 128'(rv), 128'(erv));
        end
    endtask

    // Check current outputs away from the edge, then advance one clock and the model.
    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst   = 1'b0;
        wr    = 1'b0;
        claim = 1'b0;
        addrw = '0;
        addrc = '0;
        din   = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2);
        addr_rd = {a2, a1, a0};
    endtask

    initial begin
        idle();
        set_rd(0, 0, 0);
        rst = 1'b1;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < N; i++) begin
                mr[c][i] = '0;
                mb[c][i] = 1'b0;
            end
        @(posedge clk);
        @(posedge clk);
        #1;
        step();
        check_eq("rst_regs", 128'(regs_a), 128'(0));
        check_eq("rst_busy", 128'(busy_b), 128'(0));
        idle();

        // Write r3, read it back the next cycle.
        wr = 1'b1; addrw = 3; din = 16'h1234;
        step();
        idle();
        set_rd(3, 0, 0);
        check_eq("r3_reg", 128'(regs_a[3*W +: W]), 128'(16'h1234));
        check_eq("r3_only", 128'(regs_a & ~(128'(16'hffff) << (3*W))), 128'(0));
        #1;
        check_eq("r3_rd", 128'(data_a[0 +: W]), 128'(16'h1234));
        step();

        // Same-cycle write/read of r5: forwarded on A, old value on B.
        wr = 1'b1; addrw = 5; din = 16'hBEEF;
        set_rd(0, 5, 0);
        #2;
        check_eq("byp_a", 128'(data_a[W +: W]), 128'(16'hBEEF));
        check_eq("nobyp_b", 128'(data_b[W +: W]), 128'(16'h0000));
        step();
        idle();

        // r0 is hardwired on B.
        wr = 1'b1; addrw = 0; din = 16'hFFFF; claim = 1'b1; addrc = 0;
        step();
        idle();
        set_rd(0, 0, 0);
        #1;
        check_eq("z_reg0", 128'(regs_b[0 +: W]), 128'(0));
        check_eq("z_busy0", 128'(busy_b[0]), 128'(0));
        check_eq("z_rd0", 128'(data_b[0 +: W]), 128'(0));
        step();

        // Claim r2, hold, then writeback, then claim+write together.
        claim = 1'b1; addrc = 2;
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            check_eq("clm_hold", 128'(busy_a[2]), 128'(1));
            step();
        end
        wr = 1'b1; addrw = 2; din = 16'h0042;
        step();
        idle();
        check_eq("wb_busy", 128'(busy_a[2]), 128'(0));
        check_eq("wb_data", 128'(regs_a[2*W +: W]), 128'(16'h0042));
        wr = 1'b1; addrw = 2; din = 16'h0077; claim = 1'b1; addrc = 2;
        step();
        idle();
        check_eq("cw_busy", 128'(busy_a[2]), 128'(1));
        check_eq("cw_data", 128'(regs_a[2*W +: W]), 128'(16'h0077));

        // Reset overrides a pending write and discards busy state.
        claim = 1'b1; addrc = 4; wr = 1'b1; addrw = 6; din = 16'h0A0A;
        step();
        idle();
        rst = 1'b1; wr = 1'b1; addrw = 1; din = 16'h1111;
        step();
        idle();
        check_eq("rstov_regs", 128'(regs_a), 128'(0));
        check_eq("rstov_busy", 128'(busy_a), 128'(0));
        step();

        // All ports on r7, then claimed.
        wr = 1'b1; addrw = 7; din = 16'h5555; claim = 1'b1; addrc = 7;
        step();
        idle();
        set_rd(7, 7, 7);
        #1;
        for (int p = 0; p < R; p++) begin
            check_eq("r7_rd", 128'(data_a[p*W +: W]), 128'(16'h5555));
            check_eq("r7_busy", 128'(busy_rd_a[p]), 128'(1));
        end
        step();

        for (int n = 0; n < 2000; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            wr    = $urandom_range(0, 1);
            claim = ($urandom_range(0, 2) == 0);
            addrw = AW'($urandom);
            addrc = ($urandom_range(0, 3) == 0) ? addrw : AW'($urandom);
            din   = W'($urandom);
            for (int p = 0; p < R; p++)
                addr_rd[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? addrw : AW'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", checks, errs);
        $finish;
    end

endmodule
